portal_burst_sched: RTL and testbench
=====================================

# portal_burst_sched

Burst scheduler sitting between the MAXIGP0 slave-side request FIFOs and the shared portal register port. It accepts AXI-style read (AR) and write (AW/W) burst requests and grants one burst at a time with round-robin fairness between reads and writes. It expands each granted burst into single-word register accesses, returns read data beats with their IDs, and produces one write response (B) per write burst. It replaces the independent read/write beat engines so that only one master drives the register port at any time.

## Interface
Parameters:
- ADDR_WIDTH, 13, byte address width of the register space
- ID_WIDTH, 6, transaction ID width
- DATA_WIDTH, 32, register data width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- ar_valid  in  1  read burst request present
- ar_addr  in  ADDR_WIDTH  read start byte address
- ar_len  in  4  beats minus one
- ar_id  in  ID_WIDTH  read ID
- ar_ready  out  1  read request accepted this cycle
- aw_valid / aw_addr / aw_len / aw_id  in  1/ADDR_WIDTH/4/ID_WIDTH  write burst request, same encoding as AR
- aw_ready  out  1  write request accepted this cycle
- w_valid  in  1  write data beat present
- w_data  in  DATA_WIDTH  write data
- w_ready  out  1  write beat consumed this cycle
- reg_valid  out  1  register access request
- reg_write  out  1  1 = write, 0 = read
- reg_addr  out  ADDR_WIDTH  word-aligned access address
- reg_wdata  out  DATA_WIDTH  write data (equals w_data)
- reg_ready  in  1  register port accepts the access this cycle
- reg_rdata  in  DATA_WIDTH  read data, valid in the cycle reg_valid && reg_ready && !reg_write
- r_valid / r_data / r_id / r_last  out  1/DATA_WIDTH/ID_WIDTH/1  read data beat
- r_ready  in  1  read beat consumer ready
- b_valid / b_id  out  1/ID_WIDTH  write response
- b_ready  in  1  write response consumer ready

## Operation
- FSM states: IDLE, RD, WR. State registers: addr (ADDR_WIDTH), remain (5 bits), id, prio (0 = read favoured).
- IDLE: if ar_valid && (!aw_valid || prio==0): ar_ready=1, latch ar_addr, ar_len+1, ar_id, go to RD, set prio=1. Otherwise, if aw_valid && b slot empty: aw_ready=1, latch AW fields, go to WR, set prio=0. A write is not granted while b_valid is pending; a pending read is then granted even when prio==1.
- ar_ready and aw_ready are never both 1 in the same cycle. Both are 0 outside IDLE.
- RD: reg_valid=1, reg_write=0 when r slot is free (r_valid==0 or r_ready==1). On reg handshake: load r_data=reg_rdata, r_id=id, r_last=(remain==1), set r_valid, addr+=4, remain-=1. The handshake with remain==1 returns the FSM to IDLE.
- WR: reg_valid=w_valid, reg_write=1, w_ready=reg_ready && w_valid. On handshake: addr+=4, remain-=1. The beat with remain==1 sets b_valid, b_id=id, and returns to IDLE.
- reg_addr = addr with bits [1:0] forced to 0. addr increments modulo 2^ADDR_WIDTH and wraps silently.
- r and b are single-entry output registers, cleared on r_ready / b_ready handshake.
- reg_valid is 0 in IDLE.

## Timing
- Reset values: state=IDLE, prio=0, r_valid=0, b_valid=0, reg_valid=0, ar_ready=0, aw_ready=0, w_ready=0. Data/ID outputs are 0.
- Request accepted at cycle N; first reg_valid at N+1.
- Read: reg handshake at cycle M; r_valid=1 from M+1.
- Sustained throughput is one beat per cycle with reg_ready and r_ready held 1. A 4-beat read occupies the FSM for 4 cycles after accept.
- After a burst's last handshake the FSM is in IDLE the next cycle, so the earliest next accept is one cycle later. There is one dead cycle between bursts.
- Simultaneous r_ready clear and new load of the r slot in the same cycle: the load wins, and r_valid stays 1.
- A reset in mid-burst abandons the burst. No B or r_last is produced, and the remaining W beats are not consumed until re-granted.

## Test plan
- Single read, ar_addr=0x010, len=3, reg_rdata=addr-derived, r_ready=1 -> reg_addr 0x010,0x014,0x018,0x01C on consecutive cycles. Four r beats with r_id=ar_id; r_last only on the 4th.
- Single write, aw_addr=0x004, len=0, w_data=0x1 -> one reg write to 0x004 with data 0x1. b_valid with b_id=aw_id one cycle after the handshake.
- Simultaneous ar_valid and aw_valid held for 4 bursts from reset -> grant order R, W, R, W.
- r_ready=0 during a 2-beat read -> exactly one reg access, then reg_valid=0 until r_ready=1. No data is lost, and the beat order is preserved.
- b_ready=0 with one write completed, then a new aw_valid and ar_valid -> the read is granted and aw_ready stays 0 until b is consumed.
- Address wrap: ar_addr=0x1FFC, len=1 -> reg_addr 0x1FFC then 0x0000.
- nRST asserted in mid-write burst -> all outputs return to their reset values the next cycle, and the FSM is in IDLE.

Source files
------------

// File: rtl/portal_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : portal_burst_sched
// Purpose  : Arbitrates AXI-style read (AR) and write (AW/W) burst requests
//            onto the single shared portal register port. Only one burst is
//            active at a time. Reads and writes are granted round-robin. Each
//            granted burst is expanded into single-word register accesses.
//            Read beats are returned on R, and one B response is returned per
//            write burst.
// Ports    : CLK/nRST                clock, synchronous active-low reset
//            ar_*                    read burst request (addr, len-1, id)
//            aw_* / w_*              write burst request and write data beats
//            reg_*                   shared register port (valid/ready)
//            r_*                     read data beat (single-entry register)
//            b_*                     write response (single-entry register)
// Revision : 1.0  initial release
// ============================================================================
module portal_burst_sched #(
  parameter int ADDR_WIDTH = 13,
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ar_valid,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [3:0]            ar_len,
  input  logic [ID_WIDTH-1:0]   ar_id,
  output logic                  ar_ready,
  input  logic                  aw_valid,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [3:0]            aw_len,
  input  logic [ID_WIDTH-1:0]   aw_id,
  output logic                  aw_ready,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  output logic                  reg_valid,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic                  reg_ready,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic                  r_last,
  input  logic                  r_ready,
  output logic                  b_valid,
  output logic [ID_WIDTH-1:0]   b_id,
  input  logic                  b_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [4:0]            remain;
  logic [ID_WIDTH-1:0]   id;
  logic                  prio;   // 0: read favoured, 1: write favoured

  logic grant_rd;
  logic grant_wr;
  logic r_free;
  logic rd_hs;
  logic wr_hs;
  logic last_beat;

  // A read wins when it is alone, when it has priority, or when a write
  // cannot be taken because the B slot is still occupied. Gating with nRST
  // keeps the ready outputs low while reset is held.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE && nRST) begin
      if (ar_valid && (!aw_valid || !prio || b_valid))
        grant_rd = 1'b1;
      else if (aw_valid && !b_valid)
        grant_wr = 1'b1;
    end
  end

  assign ar_ready  = grant_rd;
  assign aw_ready  = grant_wr;

  // A read access is only issued when its result has somewhere to go.
  assign r_free    = !r_valid || r_ready;
  assign reg_valid = (state == RD) ? r_free :
                     (state == WR) ? w_valid : 1'b0;
  assign reg_write = (state == WR);
  assign reg_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign reg_wdata = (state == WR) ? w_data : '0;
  assign rd_hs     = (state == RD) && r_free && reg_ready;
  assign wr_hs     = (state == WR) && w_valid && reg_ready;
  assign w_ready   = wr_hs;
  assign last_beat = (remain == 5'd1);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      addr    <= '0;
      remain  <= '0;
      id      <= '0;
      prio    <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= 1'b0;
      b_valid <= 1'b0;
      b_id    <= '0;
    end else begin
      // Consumer handshakes free the slots; a load below overrides the clear.
      if (r_valid && r_ready) r_valid <= 1'b0;
      if (b_valid && b_ready) b_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_rd) begin
            addr   <= ar_addr;
            remain <= {1'b0, ar_len} + 5'd1;
            id     <= ar_id;
            prio   <= 1'b1;
            state  <= RD;
          end else if (grant_wr) begin
            addr   <= aw_addr;
            remain <= {1'b0, aw_len} + 5'd1;
            id     <= aw_id;
            prio   <= 1'b0;
            state  <= WR;
          end
        end
        RD: begin
          if (rd_hs) begin
            r_valid <= 1'b1;
            r_data  <= reg_rdata;
            r_id    <= id;
            r_last  <= last_beat;
            addr    <= addr + ADDR_WIDTH'(4);
            remain  <= remain - 5'd1;
            if (last_beat) state <= IDLE;
          end
        end
        WR: begin
          if (wr_hs) begin
            addr   <= addr + ADDR_WIDTH'(4);
            remain <= remain - 5'd1;
            if (last_beat) begin
              b_valid <= 1'b1;
              b_id    <= id;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_portal_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_portal_burst_sched
// Purpose  : Self-checking bench for portal_burst_sched. A passive monitor
//            logs register accesses, R beats, B responses and grants; each
//            scenario task compares the logs against bursts expanded from
//            plain address arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_portal_burst_sched;
  localparam int AW = 13;
  localparam int IW = 6;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
  logic [AW-1:0] ar_addr, aw_addr, reg_addr;
  logic [3:0]    ar_len, aw_len;
  logic [IW-1:0] ar_id, aw_id, r_id, b_id;
  logic [DW-1:0] w_data, reg_wdata, reg_rdata, r_data;
  logic          reg_valid, reg_write, reg_ready;
  logic          r_valid, r_last, r_ready, b_valid, b_ready;
  logic [DW-1:0] rd_salt;

  always #5 CLK = ~CLK;

  // Register file stand-in: read data is a salted copy of the word address.
  assign reg_rdata = rd_salt ^ {19'd0, reg_addr};

  portal_burst_sched #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id), .ar_ready(ar_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_len(aw_len), .aw_id(aw_id), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ready(reg_ready), .reg_rdata(reg_rdata),
    .r_valid(r_valid), .r_data(r_data), .r_id(r_id), .r_last(r_last), .r_ready(r_ready),
    .b_valid(b_valid), .b_id(b_id), .b_ready(b_ready)
  );

  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } acc_t;
  typedef struct { logic [DW-1:0] data; logic [IW-1:0] id; logic last; int cyc; } rbeat_t;
  typedef struct { logic [IW-1:0] id; int cyc; } bresp_t;

  acc_t   acc_q[$];
  rbeat_t r_q[$];
  bresp_t b_q[$];
  byte    grant_q[$];
  int     cyc = 0;
  int     both_rdy = 0;
  int     errors = 0;
  int     checks = 0;
  bit     rnd_reg = 0;
  bit     rnd_r = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (ar_ready && aw_ready) both_rdy++;
    if (nRST) begin
      if (reg_valid && reg_ready)
        acc_q.push_back('{wr: reg_write, addr: reg_addr,
                          data: (reg_write ? reg_wdata : reg_rdata), cyc: cyc});
      if (r_valid && r_ready) r_q.push_back('{data: r_data, id: r_id, last: r_last, cyc: cyc});
      if (b_valid && b_ready) b_q.push_back('{id: b_id, cyc: cyc});
      if (ar_valid && ar_ready) grant_q.push_back("R");
      if (aw_valid && aw_ready) grant_q.push_back("W");
    end
  end

  // Random back-pressure on the register port and the R consumer.
  initial forever begin
    @(posedge CLK); #1;
    if (rnd_reg) reg_ready = 1'($urandom_range(0, 1));
    if (rnd_r)   r_ready   = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK); #1;
  endtask

  task automatic idle_inputs();
    ar_valid = 0; ar_addr = '0; ar_len = '0; ar_id = '0;
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_id = '0;
    w_valid = 0; w_data = '0;
    reg_ready = 1; r_ready = 1; b_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    tick(); tick();
    nRST = 1;
    acc_q.delete(); r_q.delete(); b_q.delete(); grant_q.delete();
  endtask

  task automatic wait_grant(input bit is_rd, output int gcyc, output bit ok);
    ok = 0; gcyc = 0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (is_rd ? (ar_valid && ar_ready) : (aw_valid && aw_ready)) begin
        gcyc = cyc; ok = 1; break;
      end
    end
    tick();
    if (is_rd) ar_valid = 0; else aw_valid = 0;
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [3:0] len,
                          input logic [IW-1:0] id, input string tag, input bit timing);
    int gcyc; bit ok; int n; logic [AW-1:0] ea;
    acc_q.delete(); r_q.delete();
    rd_salt = $urandom;
    ar_addr = a; ar_len = len; ar_id = id; ar_valid = 1;
    wait_grant(1, gcyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: ar_ready never seen", tag); return; end
    n = int'(len) + 1;
    for (int i = 0; i < 2000 && r_q.size() < n; i++) sample();
    tick();
    checks++;
    if (r_q.size() != n || acc_q.size() != n) begin
      errors++;
      $display("FAIL %s: beats got r=%0d reg=%0d expected %0d", tag, r_q.size(), acc_q.size(), n);
      return;
    end
    for (int k = 0; k < n; k++) begin
      ea = a + AW'(4 * k); ea[1:0] = 2'b00;
      checks++;
      if (acc_q[k].wr !== 1'b0 || acc_q[k].addr !== ea) begin
        errors++;
        $display("FAIL %s beat%0d access: got wr=%0b addr=%h expected wr=0 addr=%h",
                 tag, k, acc_q[k].wr, acc_q[k].addr, ea);
      end
      checks++;
      if (r_q[k].data !== (rd_salt ^ {19'd0, ea}) || r_q[k].id !== id || r_q[k].last !== (k == n - 1)) begin
        errors++;
        $display("FAIL %s beat%0d r: got data=%h id=%h last=%0b expected data=%h id=%h last=%0b",
                 tag, k, r_q[k].data, r_q[k].id, r_q[k].last, rd_salt ^ {19'd0, ea}, id, k == n - 1);
      end
      if (timing) begin
        checks++;
        if (acc_q[k].cyc != gcyc + 1 + k || r_q[k].cyc != acc_q[k].cyc + 1) begin
          errors++;
          $display("FAIL %s beat%0d timing: got access cyc=%0d r cyc=%0d expected %0d and %0d",
                   tag, k, acc_q[k].cyc, r_q[k].cyc, gcyc + 1 + k, gcyc + 2 + k);
        end
      end
    end
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [3:0] len, input logic [IW-1:0] id,
                           input string tag, input bit timing, input bit wstall,
                           input logic [DW-1:0] first);
    int gcyc; bit ok; int n; int k; logic [AW-1:0] ea; logic [DW-1:0] wd[16];
    acc_q.delete(); b_q.delete();
    for (int i = 0; i < 16; i++) wd[i] = (i == 0) ? first : $urandom;
    aw_addr = a; aw_len = len; aw_id = id; aw_valid = 1;
    wait_grant(0, gcyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: aw_ready never seen", tag); return; end
    n = int'(len) + 1;
    k = 0;
    for (int i = 0; i < 2000 && k < n; i++) begin
      w_valid = wstall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_data = wd[k];
      sample();
      if (w_valid && w_ready) k++;
      tick();
    end
    w_valid = 0; w_data = '0;
    for (int i = 0; i < 200 && b_q.size() < 1; i++) sample();
    tick();
    checks++;
    if (acc_q.size() != n || b_q.size() != 1) begin
      errors++;
      $display("FAIL %s: got reg writes=%0d b=%0d expected %0d and 1", tag, acc_q.size(), b_q.size(), n);
      return;
    end
    for (int j = 0; j < n; j++) begin
      ea = a + AW'(4 * j); ea[1:0] = 2'b00;
      checks++;
      if (acc_q[j].wr !== 1'b1 || acc_q[j].addr !== ea || acc_q[j].data !== wd[j]) begin
        errors++;
        $display("FAIL %s beat%0d access: got wr=%0b addr=%h data=%h expected wr=1 addr=%h data=%h",
                 tag, j, acc_q[j].wr, acc_q[j].addr, acc_q[j].data, ea, wd[j]);
      end
      if (timing) begin
        checks++;
        if (acc_q[j].cyc != gcyc + 1 + j) begin
          errors++;
          $display("FAIL %s beat%0d timing: got cyc=%0d expected %0d", tag, j, acc_q[j].cyc, gcyc + 1 + j);
        end
      end
    end
    checks++;
    if (b_q[0].id !== id) begin
      errors++; $display("FAIL %s b_id: got %h expected %h", tag, b_q[0].id, id);
    end
    if (timing) begin
      checks++;
      if (b_q[0].cyc != acc_q[n-1].cyc + 1) begin
        errors++;
        $display("FAIL %s b timing: got cyc=%0d expected %0d", tag, b_q[0].cyc, acc_q[n-1].cyc + 1);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({ar_ready, aw_ready, w_ready, reg_valid, reg_write, r_valid, r_last, b_valid} !== 8'b0) begin
      errors++;
      $display("FAIL %s flags: got ar=%0b aw=%0b w=%0b reg_v=%0b reg_w=%0b r_v=%0b r_last=%0b b_v=%0b expected all 0",
               tag, ar_ready, aw_ready, w_ready, reg_valid, reg_write, r_valid, r_last, b_valid);
    end
    checks++;
    if ({reg_addr, reg_wdata, r_data, r_id, b_id} !== '0) begin
      errors++;
      $display("FAIL %s data: got reg_addr=%h reg_wdata=%h r_data=%h r_id=%h b_id=%h expected 0",
               tag, reg_addr, reg_wdata, r_data, r_id, b_id);
    end
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    check_zero_outputs("reset");
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    run_read(13'h010, 4'd3, 6'h2A, "single_rd", 1);
  endtask

  task automatic test_single_write();
    idle_inputs();
    run_write(13'h004, 4'd0, 6'h15, "single_wr", 1, 0, 32'h1);
  endtask

  task automatic test_grant_order();
    logic [31:0] seq; logic [3:0] kinds;
    do_reset();
    ar_addr = 13'h100; ar_len = 0; ar_id = 6'h11;
    aw_addr = 13'h200; aw_len = 0; aw_id = 6'h22;
    w_valid = 1; w_data = 32'hDEAD0000;
    ar_valid = 1; aw_valid = 1;
    for (int i = 0; i < 100 && grant_q.size() < 4; i++) sample();
    tick();
    ar_valid = 0; aw_valid = 0;
    repeat (4) tick();
    w_valid = 0;
    checks++;
    if (grant_q.size() != 4 || acc_q.size() != 4) begin
      errors++;
      $display("FAIL grant_order: got grants=%0d accesses=%0d expected 4 and 4", grant_q.size(), acc_q.size());
    end else begin
      seq = {grant_q[0], grant_q[1], grant_q[2], grant_q[3]};
      kinds = {acc_q[0].wr, acc_q[1].wr, acc_q[2].wr, acc_q[3].wr};
      checks++;
      if (seq !== "RWRW") begin
        errors++; $display("FAIL grant_order: got %s expected RWRW", seq);
      end
      checks++;
      if (kinds !== 4'b0101) begin
        errors++; $display("FAIL grant_order accesses: got wr pattern %b expected 0101", kinds);
      end
    end
  endtask

  task automatic test_r_backpressure();
    int g; bit ok;
    idle_inputs(); r_ready = 0;
    acc_q.delete(); r_q.delete(); rd_salt = $urandom;
    ar_addr = 13'h0A0; ar_len = 1; ar_id = 6'h33; ar_valid = 1;
    wait_grant(1, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL r_stall: ar_ready never seen"); end
    repeat (8) sample();
    checks++;
    if (acc_q.size() != 1 || reg_valid !== 1'b0 || r_valid !== 1'b1) begin
      errors++;
      $display("FAIL r_stall hold: got accesses=%0d reg_valid=%0b r_valid=%0b expected 1, 0, 1",
               acc_q.size(), reg_valid, r_valid);
    end
    tick();
    r_ready = 1;
    for (int i = 0; i < 50 && r_q.size() < 2; i++) sample();
    tick();
    checks++;
    if (r_q.size() != 2 || acc_q.size() != 2) begin
      errors++;
      $display("FAIL r_stall drain: got r=%0d accesses=%0d expected 2 and 2", r_q.size(), acc_q.size());
    end else begin
      checks++;
      if (r_q[0].data !== (rd_salt ^ 32'h0A0) || r_q[0].last !== 1'b0 ||
          r_q[1].data !== (rd_salt ^ 32'h0A4) || r_q[1].last !== 1'b1) begin
        errors++;
        $display("FAIL r_stall order: got %h/%0b %h/%0b expected %h/0 %h/1", r_q[0].data, r_q[0].last,
                 r_q[1].data, r_q[1].last, rd_salt ^ 32'h0A0, rd_salt ^ 32'h0A4);
      end
    end
  endtask

  task automatic test_b_backpressure();
    int g; bit ok; int nr; int nw;
    idle_inputs(); b_ready = 0;
    b_q.delete();
    aw_addr = 13'h040; aw_len = 0; aw_id = 6'h01; aw_valid = 1;
    w_valid = 1; w_data = 32'h12345678;
    wait_grant(0, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_stall: first aw_ready never seen"); end
    repeat (3) sample();
    checks++;
    if (b_valid !== 1'b1 || b_id !== 6'h01) begin
      errors++; $display("FAIL b_stall pending: got b_valid=%0b b_id=%h expected 1 and 01", b_valid, b_id);
    end
    tick();
    w_valid = 0;
    grant_q.delete();
    ar_addr = 13'h080; ar_len = 0; ar_id = 6'h02; ar_valid = 1;
    aw_addr = 13'h0C0; aw_len = 0; aw_id = 6'h03; aw_valid = 1;
    wait_grant(1, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_stall: read not granted while b pending"); end
    repeat (12) sample();
    nr = 0; nw = 0;
    foreach (grant_q[i]) if (grant_q[i] == "R") nr++; else nw++;
    checks++;
    if (nr != 1 || nw != 0 || aw_ready !== 1'b0) begin
      errors++;
      $display("FAIL b_stall grants: got reads=%0d writes=%0d aw_ready=%0b expected 1, 0, 0", nr, nw, aw_ready);
    end
    tick();
    b_ready = 1; w_valid = 1; w_data = 32'h0BAD0BAD;
    wait_grant(0, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_stall: write not granted after b consumed"); end
    for (int i = 0; i < 50 && b_q.size() < 2; i++) sample();
    tick();
    w_valid = 0;
    checks++;
    if (b_q.size() != 2) begin
      errors++; $display("FAIL b_stall responses: got %0d expected 2", b_q.size());
    end else begin
      checks++;
      if (b_q[0].id !== 6'h01 || b_q[1].id !== 6'h03) begin
        errors++; $display("FAIL b_stall ids: got %h %h expected 01 03", b_q[0].id, b_q[1].id);
      end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    run_read(13'h1FFC, 4'd1, 6'h07, "wrap", 1);
    checks++;
    if (acc_q.size() != 2 || acc_q[0].addr !== 13'h1FFC || acc_q[1].addr !== 13'h0000) begin
      errors++;
      $display("FAIL wrap addrs: got count=%0d expected 1ffc then 0000", acc_q.size());
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [3:0] l; logic [IW-1:0] id;
    idle_inputs();
    rnd_reg = 1; rnd_r = 1;
    for (int t = 0; t < 24; t++) begin
      a = AW'($urandom); l = 4'($urandom); id = IW'($urandom);
      if ($urandom_range(0, 1) == 1) run_read(a, l, id, "rand_rd", 0);
      else                           run_write(a, l, id, "rand_wr", 0, 1, $urandom);
    end
    rnd_reg = 0; rnd_r = 0;
    tick();
    reg_ready = 1; r_ready = 1;
    tick();
  endtask

  task automatic test_reset_midburst();
    int g; bit ok;
    idle_inputs();
    aw_addr = 13'h300; aw_len = 4'd7; aw_id = 6'h2C; aw_valid = 1;
    w_valid = 1; w_data = 32'hFACE0001;
    wait_grant(0, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reset: aw_ready never seen"); end
    repeat (3) tick();
    nRST = 0;
    tick();
    sample();
    check_zero_outputs("mid_reset");
    tick();
    nRST = 1;
    acc_q.delete(); b_q.delete(); r_q.delete();
    repeat (5) sample();
    checks++;
    if (acc_q.size() != 0 || b_q.size() != 0 || w_ready !== 1'b0 || reg_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset after: got accesses=%0d b=%0d w_ready=%0b reg_valid=%0b expected all 0",
               acc_q.size(), b_q.size(), w_ready, reg_valid);
    end
    tick();
    w_valid = 0;
    ar_addr = 13'h010; ar_len = 0; ar_id = 6'h04; ar_valid = 1;
    wait_grant(1, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reset: FSM not back in IDLE, ar_ready never seen"); end
    repeat (4) tick();
  endtask

  task automatic test_exclusive_ready();
    checks++;
    if (both_rdy != 0) begin
      errors++; $display("FAIL exclusive_ready: ar_ready and aw_ready both high in %0d cycles, expected 0", both_rdy);
    end
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    rd_salt = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_grant_order();
    test_r_backpressure();
    test_b_backpressure();
    test_wrap();
    test_random();
    test_reset_midburst();
    test_exclusive_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
